// File: rtl/cpm_pkg.sv
// cpm_pkg: shared widths, frame length and FSM states for the CPM readout.
// Frame grows by a trailing parity bit when CPM_READOUT_PARITY_EN is defined.
package cpm_pkg;
  localparam int WIDTH = 16;
  localparam int CODE_W = 5;
  localparam int NSAMP_W = 4;
  localparam int SYNC_STAGES = 2;
  function automatic int sum_w(input int code_w, input int nsamp_w);
    return code_w + nsamp_w;
  endfunction
  localparam int SUM_W = sum_w(CODE_W, NSAMP_W);
  localparam int DATA_W = 1 + 2 * CODE_W + SUM_W;
`ifdef CPM_READOUT_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W);
  typedef enum logic [2:0] {IDLE, SYNC, SAMPLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/cpm_readout_if.sv
// cpm_readout_if: thermometer input, burst control and serial result of the CPM readout.
interface cpm_readout_if;
  logic [1:cpm_pkg::WIDTH] CPM_OUT;
  logic START;
  logic [cpm_pkg::NSAMP_W-1:0] NSAMP;
  logic BUSY;
  logic DONE;
  logic SO;
  logic SO_VLD;
  logic [cpm_pkg::CODE_W-1:0] MIN_CODE;
  logic [cpm_pkg::CODE_W-1:0] MAX_CODE;
  logic [cpm_pkg::SUM_W-1:0] SUM_CODE;
  logic BUBBLE_ERR;
  modport master (
    output CPM_OUT, START, NSAMP,
    input BUSY, DONE, SO, SO_VLD, MIN_CODE, MAX_CODE, SUM_CODE, BUBBLE_ERR
  );
  modport slave (
    input CPM_OUT, START, NSAMP,
    output BUSY, DONE, SO, SO_VLD, MIN_CODE, MAX_CODE, SUM_CODE, BUBBLE_ERR
  );
endinterface

// File: rtl/cpm_therm_enc.sv
// cpm_therm_enc: thermometer word to leading-ones count, flagging any 1 after the first 0.
module cpm_therm_enc #(
  parameter int WIDTH = 16,
  parameter int CODE_W = 5
) (
  input  logic [1:WIDTH]    i_therm,
  output logic [CODE_W-1:0] o_code,
  output logic              o_bubble
);
  logic w_run;
  always_comb begin
    o_code = '0;
    o_bubble = 1'b0;
    w_run = 1'b1;
    for (int k = 1; k <= WIDTH; k++) begin
      if (!i_therm[k]) w_run = 1'b0;
      else if (w_run) o_code = o_code + CODE_W'(1);
      else o_bubble = 1'b1;
    end
  end
endmodule

// File: rtl/cpm_readout.sv
// cpm_readout: synchronise CPM thermometer, accumulate min/max/sum over a burst, shift result out.
// Build option CPM_READOUT_PARITY_EN appends an even-parity bit to the serial frame.
module cpm_readout
  import cpm_pkg::*;
(
  input logic SC_CLK,
  input logic RST,
  cpm_readout_if.slave bus
);
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0][1:WIDTH] r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [NSAMP_W-1:0] r_nsamp;
  logic [CODE_W-1:0] r_min, r_max, r_min_o, r_max_o, w_code, w_min, w_max;
  logic [SUM_W-1:0] r_sum, r_sum_o, w_sum;
  logic r_bub, r_bub_o, w_bubble, w_bub, w_first, w_start, w_last;
  logic [DATA_W-1:0] w_data;
  logic [FRAME_W-1:0] r_sh, w_frame;

  cpm_therm_enc #(.WIDTH(WIDTH), .CODE_W(CODE_W)) u_enc (
    .i_therm (r_sync[SYNC_STAGES-1]),
    .o_code  (w_code),
    .o_bubble(w_bubble)
  );

  always_ff @(posedge SC_CLK or negedge RST)
    if (!RST) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.START ? SYNC : IDLE;
      SYNC:    w_next = (r_cnt == CNT_W'(SYNC_STAGES - 1)) ? SAMPLE : SYNC;
      SAMPLE:  w_next = (r_cnt == CNT_W'(r_nsamp)) ? SHIFT : SAMPLE;
      SHIFT:   w_next = (r_cnt == CNT_W'(FRAME_W - 1)) ? DONE : SHIFT;
      default: w_next = IDLE;
    endcase
  end

  assign w_start = (r_state == IDLE) && bus.START;
  assign w_last = (r_state == SAMPLE) && (w_next == SHIFT);
  assign w_first = r_cnt == '0;
  assign w_min = (w_first || w_code < r_min) ? w_code : r_min;
  assign w_max = (w_first || w_code > r_max) ? w_code : r_max;
  assign w_sum = (w_first ? SUM_W'(0) : r_sum) + SUM_W'(w_code);
  assign w_bub = (!w_first && r_bub) || w_bubble;
  assign w_data = {w_bub, w_min, w_max, w_sum};
`ifdef CPM_READOUT_PARITY_EN
  assign w_frame = {w_data, ^w_data};
`else
  assign w_frame = w_data;
`endif

  // One counter times SYNC, SAMPLE and SHIFT; it restarts on every state change.
  always_ff @(posedge SC_CLK or negedge RST)
    if (!RST) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_nsamp <= '0;
      r_min <= '0;
      r_max <= '0;
      r_sum <= '0;
      r_bub <= 1'b0;
      r_min_o <= '0;
      r_max_o <= '0;
      r_sum_o <= '0;
      r_bub_o <= 1'b0;
      r_sh <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.CPM_OUT};
      r_cnt <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + 1'b1;
      if (w_start) begin
        r_nsamp <= bus.NSAMP;
        r_min <= '0;
        r_max <= '0;
        r_sum <= '0;
        r_bub <= 1'b0;
      end
      if (r_state == SAMPLE) begin
        r_min <= w_min;
        r_max <= w_max;
        r_sum <= w_sum;
        r_bub <= w_bub;
      end
      if (w_last) begin
        r_min_o <= w_min;
        r_max_o <= w_max;
        r_sum_o <= w_sum;
        r_bub_o <= w_bub;
        r_sh <= w_frame;
      end else if (r_state == SHIFT) r_sh <= r_sh << 1;
    end

  assign bus.BUSY = r_state != IDLE;
  assign bus.DONE = r_state == DONE;
  assign bus.SO_VLD = r_state == SHIFT;
  assign bus.SO = (r_state == SHIFT) && r_sh[FRAME_W-1];
  assign bus.MIN_CODE = r_min_o;
  assign bus.MAX_CODE = r_max_o;
  assign bus.SUM_CODE = r_sum_o;
  assign bus.BUBBLE_ERR = r_bub_o;
endmodule

// File: tb/tb_cpm_readout.sv
// tb_cpm_readout: randomized bursts scored against a leading-ones/popcount reference model.
module tb_cpm_readout;
  import cpm_pkg::*;

  typedef struct packed {
    logic [FRAME_W-1:0] frame;
    logic [CODE_W-1:0]  mn;
    logic [CODE_W-1:0]  mx;
    logic [SUM_W-1:0]   sm;
    logic               bub;
    int                 due;
  } exp_t;

  logic SC_CLK = 1'b0;
  logic RST = 1'b1;
  cpm_readout_if bus();
  cpm_readout dut (.SC_CLK(SC_CLK), .RST(RST), .bus(bus));

  always #5 SC_CLK = ~SC_CLK;

  exp_t q[$];
  exp_t held, em;
  int checks = 0, fails = 0, cyc = 0, nbits = 0, first_cyc = 0;
  logic [FRAME_W-1:0] got = '0;

  always @(posedge SC_CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] therm(input int c);
    logic [15:0] ones = 16'hFFFF;
    return ~(ones >> c);
  endfunction

  // Code is the run of leading ones; a bubble means the popcount exceeds that run.
  function automatic exp_t model(input logic [15:0] ws[$], input int due);
    exp_t r;
    int c;
    logic [DATA_W-1:0] d;
    r = '0;
    foreach (ws[i]) begin
      c = 0;
      while (c < 16 && ws[i][15-c]) c++;
      if (i == 0 || c < int'(r.mn)) r.mn = CODE_W'(c);
      if (i == 0 || c > int'(r.mx)) r.mx = CODE_W'(c);
      r.sm = r.sm + SUM_W'(c);
      if ($countones(ws[i]) != c) r.bub = 1'b1;
    end
    d = {r.bub, r.mn, r.mx, r.sm};
`ifdef CPM_READOUT_PARITY_EN
    r.frame = {d, ^d};
`else
    r.frame = d;
`endif
    r.due = due;
    return r;
  endfunction

  always @(negedge SC_CLK) begin
    if (!RST) begin
      nbits = 0;
      got = '0;
    end else begin
      if (bus.SO_VLD) begin
        if (nbits == 0) first_cyc = cyc;
        got = {got[FRAME_W-2:0], bus.SO};
        nbits++;
      end
      if (bus.DONE) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_frame got=%0h exp=none", got);
        end else begin
          em = q.pop_front();
          chk("frame", 32'(got), 32'(em.frame));
          chk("frame_bits", nbits, FRAME_W);
          chk("latency", first_cyc, em.due);
          chk("min_code", 32'(bus.MIN_CODE), 32'(em.mn));
          chk("max_code", 32'(bus.MAX_CODE), 32'(em.mx));
          chk("sum_code", 32'(bus.SUM_CODE), 32'(em.sm));
          chk("bubble_err", 32'(bus.BUBBLE_ERR), 32'(em.bub));
        end
        nbits = 0;
        got = '0;
      end
    end
  end

  task automatic run(input logic [15:0] w, input int n, input bit alt, input bit pm, input bit pd);
    logic [15:0] ws[$];
    exp_t e;
    bit done = 1'b0;
    for (int i = 0; i <= n; i++) ws.push_back((alt && i % 2 == 0) ? ~w : w);
    @(posedge SC_CLK); #1;
    e = model(ws, cyc + n + 4);
    bus.CPM_OUT = w;
    bus.NSAMP = NSAMP_W'(n);
    bus.START = 1'b1;
    q.push_back(e);
    for (int i = 1; i < 200 && !done; i++) begin
      @(posedge SC_CLK); #1;
      bus.START = 1'b0;
      bus.NSAMP = NSAMP_W'($urandom);
      if (alt) bus.CPM_OUT = ~bus.CPM_OUT;
      if (i == 2) begin
        chk("busy", 32'(bus.BUSY), 1);
        chk("hold_min", 32'(bus.MIN_CODE), 32'(held.mn));
        chk("hold_sum", 32'(bus.SUM_CODE), 32'(held.sm));
        chk("hold_bub", 32'(bus.BUBBLE_ERR), 32'(held.bub));
      end
      if (i == 4 && pm) bus.START = 1'b1;
      if (bus.DONE) begin
        done = 1'b1;
        if (pd) bus.START = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL done_timeout got=no_done exp=done");
    end
    @(posedge SC_CLK); #1;
    bus.START = 1'b0;
    chk("idle_after_done", 32'(bus.BUSY), 0);
    held = e;
  endtask

  initial begin
    bit seen;
    held = '0;
    bus.CPM_OUT = '0;
    bus.START = 1'b0;
    bus.NSAMP = '0;
    #1 RST = 1'b0;
    repeat (3) @(posedge SC_CLK);
    #1;
    chk("rst_busy", 32'(bus.BUSY), 0);
    chk("rst_done", 32'(bus.DONE), 0);
    chk("rst_so", 32'(bus.SO), 0);
    chk("rst_so_vld", 32'(bus.SO_VLD), 0);
    chk("rst_results", 32'({bus.MIN_CODE, bus.MAX_CODE, bus.SUM_CODE, bus.BUBBLE_ERR}), 0);
    RST = 1'b1;

    run(16'hFF00, 3, 0, 0, 0);
    chk("t1_min", 32'(bus.MIN_CODE), 8);
    chk("t1_sum", 32'(bus.SUM_CODE), 32);
    run(16'hFFFF, 1, 1, 0, 0);
    chk("t2_min", 32'(bus.MIN_CODE), 0);
    chk("t2_max", 32'(bus.MAX_CODE), 16);
    chk("t2_sum", 32'(bus.SUM_CODE), 16);
    run(16'hE800, 0, 0, 0, 0);
    chk("t3_min", 32'(bus.MIN_CODE), 3);
    chk("t3_bubble", 32'(bus.BUBBLE_ERR), 1);
    run(therm(11), 5, 0, 1, 1);

    @(posedge SC_CLK); #1;
    bus.CPM_OUT = therm(5);
    bus.NSAMP = 4'd2;
    bus.START = 1'b1;
    @(posedge SC_CLK); #1;
    bus.START = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge SC_CLK); #1;
      seen = bus.SO_VLD;
    end
    chk("abort_reached_shift", 32'(seen), 1);
    repeat (3) @(posedge SC_CLK);
    #1 RST = 1'b0;
    #1;
    chk("abort_so_vld", 32'(bus.SO_VLD), 0);
    chk("abort_busy", 32'(bus.BUSY), 0);
    chk("abort_results", 32'({bus.MIN_CODE, bus.MAX_CODE, bus.SUM_CODE, bus.BUBBLE_ERR}), 0);
    @(posedge SC_CLK); #1;
    RST = 1'b1;
    held = '0;
    run(therm(7), 2, 0, 0, 0);

    for (int k = 0; k < 24; k++)
      run(($urandom % 4 == 0) ? 16'($urandom) : therm($urandom % 17), $urandom % 16, 0, 0, 0);

    repeat (5) @(posedge SC_CLK);
    chk("pending_frames", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
